// File: rtl/miner_dispatch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | miner_dispatch_if : host byte stream, miner job/result and status bus     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface miner_dispatch_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [255:0] midstate;
    logic [95:0]  data2;
    logic         start_mining;
    logic         miner_busy;
    logic         got_ticket;
    logic [31:0]  golden_nonce;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         dispatch_busy;
    logic         err_arm;

    modport slave (
        input  rx_data, rx_valid, miner_busy, got_ticket, golden_nonce, tx_ready,
        output rx_ready, midstate, data2, start_mining, tx_data, tx_valid,
               dispatch_busy, err_arm
    );

    modport master (
        output rx_data, rx_valid, miner_busy, got_ticket, golden_nonce, tx_ready,
        input  rx_ready, midstate, data2, start_mining, tx_data, tx_valid,
               dispatch_busy, err_arm
    );
endinterface
`default_nettype wire

// File: rtl/miner_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | miner_dispatch : 44-byte job assembler, miner sequencer, nonce reporter   |
// | Optional macro MINER_DISPATCH_RXGAP_EN discards stale partial frames.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module miner_dispatch #(
    parameter int START_HOLD  = 4,
    parameter int ARM_TIMEOUT = 16,
    parameter int DRAIN       = 6,
    parameter int RX_GAP      = 1000000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    miner_dispatch_if.slave bus
);
    localparam int c_MAX_A = (START_HOLD > ARM_TIMEOUT) ? START_HOLD : ARM_TIMEOUT;
    localparam int c_TMAX  = (c_MAX_A > DRAIN) ? c_MAX_A : DRAIN;
    localparam int c_TW    = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam logic [c_TW-1:0] c_HOLD_LAST  = c_TW'(START_HOLD - 1);
    localparam logic [c_TW-1:0] c_ARM_LAST   = c_TW'(ARM_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_DRAIN_LAST = c_TW'(DRAIN - 1);
    localparam logic [5:0]      c_CNT_LAST   = 6'd43;
    localparam logic [5:0]      c_CNT_FULL   = 6'd44;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4,
        S_DRAIN     = 3'd5,
        S_SEND      = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [351:0]    r_frame;
    logic [5:0]      r_cnt, w_cnt_nxt;
    logic            r_pend, w_pend_nxt;
    logic [c_TW-1:0] r_tmr;
    logic [31:0]     r_result;
    logic [1:0]      r_byte_idx;
    logic [1:0]      w_idx_nxt;
    logic            w_accept, w_load, w_tx_fire, w_ticket, w_arm_expire, w_gap_hit;

    assign w_accept  = bus.rx_valid && bus.rx_ready;
    assign w_load    = (r_state == S_LOAD);
    assign w_tx_fire = bus.tx_valid && bus.tx_ready;
    assign w_idx_nxt = r_byte_idx + 2'd1;

`ifdef MINER_DISPATCH_RXGAP_EN
    logic [31:0] r_gap;
    // A completed-but-unloaded frame (count 44) is never treated as partial.
    assign w_gap_hit = (r_gap >= 32'(RX_GAP)) && (r_cnt != 6'd0) && (r_cnt != c_CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (w_accept || w_gap_hit) begin
            r_gap <= '0;
        end else if (r_gap != '1) begin
            r_gap <= r_gap + 32'd1;
        end
    end
`else
    assign w_gap_hit = 1'b0;
`endif

    // Frame bookkeeping: a second full frame arriving while one is pending
    // parks the count at 44 and stalls rx until LOAD takes the latest frame.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = r_pend;
        if (w_load) begin
            w_pend_nxt = 1'b0;
            if (r_cnt == c_CNT_FULL) w_cnt_nxt = 6'd0;
        end
        if (w_accept) begin
            if (r_cnt == c_CNT_LAST) begin
                if (r_pend && !w_load) begin
                    w_cnt_nxt = c_CNT_FULL;
                end else begin
                    w_pend_nxt = 1'b1;
                    w_cnt_nxt  = 6'd0;
                end
            end else begin
                w_cnt_nxt = r_cnt + 6'd1;
            end
        end else if (w_gap_hit) begin
            w_cnt_nxt = 6'd0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ticket     = 1'b0;
        w_arm_expire = 1'b0;
        case (r_state)
            S_IDLE:      if (r_pend) w_state_nxt = S_LOAD;
            S_LOAD:      w_state_nxt = S_START;
            S_START:     if (r_tmr == c_HOLD_LAST) w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (bus.miner_busy) begin
                    w_state_nxt = S_RUN;
                end else if (r_tmr == c_ARM_LAST) begin
                    w_state_nxt  = S_IDLE;
                    w_arm_expire = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.got_ticket) begin
                    w_state_nxt = S_SEND;
                    w_ticket    = 1'b1;
                end else if (r_pend) begin
                    w_state_nxt = S_LOAD;
                end else if (!bus.miner_busy) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.got_ticket) begin
                    w_state_nxt = S_SEND;
                    w_ticket    = 1'b1;
                end else if (r_pend) begin
                    w_state_nxt = S_LOAD;
                end else if (r_tmr == c_DRAIN_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND:      if (w_tx_fire && (r_byte_idx == 2'd3)) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame           <= '0;
            r_cnt             <= '0;
            r_pend            <= 1'b0;
            r_tmr             <= '0;
            r_result          <= '0;
            r_byte_idx        <= '0;
            bus.rx_ready      <= 1'b1;
            bus.midstate      <= '0;
            bus.data2         <= '0;
            bus.start_mining  <= 1'b0;
            bus.tx_valid      <= 1'b0;
            bus.tx_data       <= '0;
            bus.dispatch_busy <= 1'b0;
            bus.err_arm       <= 1'b0;
        end else begin
            if (w_accept) r_frame <= {bus.rx_data, r_frame[351:8]};
            r_cnt        <= w_cnt_nxt;
            r_pend       <= w_pend_nxt;
            bus.rx_ready <= !(w_pend_nxt && (w_cnt_nxt == c_CNT_FULL));

            if (w_state_nxt != r_state) begin
                r_tmr <= '0;
            end else if ((r_state == S_START) || (r_state == S_WAIT_BUSY) ||
                         (r_state == S_DRAIN)) begin
                r_tmr <= r_tmr + c_TW'(1);
            end

            if (w_load) begin
                bus.midstate <= r_frame[255:0];
                bus.data2    <= r_frame[351:256];
            end
            bus.start_mining  <= (w_state_nxt == S_START);
            bus.dispatch_busy <= (w_state_nxt != S_IDLE);
            bus.err_arm       <= w_arm_expire;

            if (w_ticket) begin
                r_result     <= bus.golden_nonce;
                r_byte_idx   <= 2'd0;
                bus.tx_valid <= 1'b1;
                bus.tx_data  <= bus.golden_nonce[7:0];
            end else if (w_tx_fire) begin
                if (r_byte_idx == 2'd3) begin
                    bus.tx_valid <= 1'b0;
                end else begin
                    r_byte_idx  <= w_idx_nxt;
                    bus.tx_data <= r_result[{w_idx_nxt, 3'b000} +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_miner_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_miner_dispatch : directed bench with tx-byte scoreboard                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_miner_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    miner_dispatch_if ifc();

    miner_dispatch #(.RX_GAP(100)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   exp_q[$];
    logic [351:0] exp_frame;
    logic         tx_tog = 1'b0;

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        while (!ifc.rx_ready && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) chk("rx_ready_timeout", 352'(ifc.rx_ready), 352'(1));
        tick;
        ifc.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int k = 0; k < 44; k++) begin
            exp_frame[8*k +: 8] = base + 8'(k);
            send_byte(base + 8'(k));
        end
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (!ifc.start_mining && lat < 20) begin
            tick;
            lat++;
        end
        chk("start_rise", 352'(ifc.start_mining), 352'(1));
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (ifc.start_mining && n < 20) begin
            tick;
            n++;
        end
    endtask

    task automatic check_job;
        chk("job_midstate", 352'(ifc.midstate), 352'(exp_frame[255:0]));
        chk("job_data2", 352'(ifc.data2), 352'(exp_frame[351:256]));
    endtask

    task automatic wait_idle(input string tag, input int want);
        int n = 0;
        while (ifc.dispatch_busy && n < 60) begin
            tick;
            n++;
        end
        chk(tag, 352'(n), 352'(want));
    endtask

    task automatic drain_sb;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick;
            n++;
        end
        chk("sb_drained", 352'(exp_q.size()), 352'(0));
    endtask

    // tx_ready source: steady high, or alternating while tx_tog is set
    initial begin
        ifc.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ifc.tx_ready = tx_tog ? ~ifc.tx_ready : 1'b1;
        end
    end

    // tx monitor: pops the scoreboard on each transfer and checks stall stability
    initial begin
        logic       hold_chk;
        logic [7:0] held;
        hold_chk = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (hold_chk) chk("tx_hold", 352'({ifc.tx_valid, ifc.tx_data}), 352'({1'b1, held}));
            hold_chk = 1'b0;
            if (rst_n && ifc.tx_valid) begin
                if (ifc.tx_ready) begin
                    if (exp_q.size() == 0) chk("tx_unexpected", 352'(ifc.tx_valid), 352'(0));
                    else                   chk("tx_byte", 352'(ifc.tx_data), 352'(exp_q.pop_front()));
                end else begin
                    hold_chk = 1'b1;
                    held     = ifc.tx_data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        rst_n            = 1'b0;
        ifc.rx_data      = '0;
        ifc.rx_valid     = 1'b0;
        ifc.miner_busy   = 1'b0;
        ifc.got_ticket   = 1'b0;
        ifc.golden_nonce = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_midstate", 352'(ifc.midstate), 352'(0));
        chk("rst_data2", 352'(ifc.data2), 352'(0));
        chk("rst_ctl", 352'({ifc.start_mining, ifc.tx_valid, ifc.rx_ready,
                             ifc.dispatch_busy, ifc.err_arm}), 352'(5'b00100));
        chk("rst_tx_data", 352'(ifc.tx_data), 352'(0));
        rst_n = 1'b1;
        tick;

        // Job 1: bytes 0x00..0x2B, miner finds 0x1234ABCD after dropping busy
        send_frame(8'h00);
        wait_start(lat);
        chk("start_latency", 352'(lat), 352'(2));
        check_job;
        chk("ms_b0", 352'(ifc.midstate[7:0]), 352'(8'h00));
        chk("ms_b31", 352'(ifc.midstate[255:248]), 352'(8'h1F));
        chk("d2_b32", 352'(ifc.data2[7:0]), 352'(8'h20));
        chk("d2_b43", 352'(ifc.data2[95:88]), 352'(8'h2B));
        chk("busy_flag", 352'(ifc.dispatch_busy), 352'(1));
        count_high(n);
        chk("start_len", 352'(n), 352'(4));
        ifc.miner_busy = 1'b1;
        repeat (3) tick;
        ifc.miner_busy = 1'b0;
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        tick;
        ifc.got_ticket   = 1'b1;
        ifc.golden_nonce = 32'h1234ABCD;
        tx_tog           = 1'b1;
        tick;
        chk("tx_latency", 352'({ifc.tx_valid, ifc.tx_data}), 352'({1'b1, 8'hCD}));
        drain_sb;
        ifc.got_ticket = 1'b0;
        tick;
        tick;
        chk("idle_after_send", 352'({ifc.dispatch_busy, ifc.tx_valid}), 352'(0));

        // Job 2: miner never arms
        send_frame(8'h80);
        wait_start(lat);
        check_job;
        count_high(n);
        n = 0;
        while (!ifc.err_arm && n < 40) begin
            tick;
            n++;
        end
        chk("arm_delay", 352'(n), 352'(16));
        chk("arm_idle", 352'(ifc.dispatch_busy), 352'(0));
        tick;
        chk("arm_pulse", 352'(ifc.err_arm), 352'(0));

        // Job 3: busy falls, no ticket
        send_frame(8'h30);
        wait_start(lat);
        check_job;
        count_high(n);
        ifc.miner_busy = 1'b1;
        repeat (3) tick;
        ifc.miner_busy = 1'b0;
        wait_idle("drain_idle", 7);

        // Job 4: ticket three cycles after busy falls
        send_frame(8'h50);
        wait_start(lat);
        count_high(n);
        ifc.miner_busy = 1'b1;
        repeat (3) tick;
        ifc.miner_busy = 1'b0;
        repeat (3) tick;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hDE);
        ifc.got_ticket   = 1'b1;
        ifc.golden_nonce = 32'hDEADBEEF;
        drain_sb;
        ifc.got_ticket = 1'b0;
        tick;
        tick;
        chk("late_ticket_idle", 352'(ifc.dispatch_busy), 352'(0));

        // Job 5: new frame completes during RUN and replaces the running job
        send_frame(8'h40);
        wait_start(lat);
        count_high(n);
        ifc.miner_busy = 1'b1;
        repeat (2) tick;
        send_frame(8'hC0);
        wait_start(lat);
        chk("abort_latency", 352'(lat), 352'(2));
        check_job;
        chk("abort_d2_top", 352'(ifc.data2[95:88]), 352'(8'hEB));
        count_high(n);
        chk("restart_len", 352'(n), 352'(4));
        repeat (2) tick;
        ifc.miner_busy = 1'b0;
        wait_idle("abort_idle", 7);

`ifdef MINER_DISPATCH_RXGAP_EN
        // Stale partial frame is discarded after the gap
        for (int i = 0; i < 10; i++) send_byte(8'h55);
        repeat (110) tick;
        send_frame(8'h10);
        wait_start(lat);
        check_job;
        chk("gap_ms_b0", 352'(ifc.midstate[7:0]), 352'(8'h10));
        count_high(n);
        n = 0;
        while (ifc.dispatch_busy && n < 40) begin
            tick;
            n++;
        end
        chk("gap_idle", 352'(ifc.dispatch_busy), 352'(0));
`endif

        // Reset mid-job drops the level outputs at once
        send_frame(8'h60);
        wait_start(lat);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 352'({ifc.start_mining, ifc.dispatch_busy, ifc.rx_ready}), 352'(3'b001));
        chk("rst_async_ms", 352'(ifc.midstate), 352'(0));
        tick;
        rst_n = 1'b1;
        tick;

        chk("sb_empty", 352'(exp_q.size()), 352'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/miner_dispatch.md
# miner_dispatch

Work dispatcher and result reporter for the SHA-256 double-hash miner core. It assembles a 44-byte job (32-byte midstate plus 12-byte data tail) from the host-side byte receiver and drives the miner's `midstate`/`data2`/`start_mining` inputs. It then monitors `miner_busy`/`got_ticket`/`golden_nonce` and returns a found nonce to the host-side byte transmitter as 4 bytes. Sits between the UART byte layer and the miner core, in the same clock domain as the UART logic.

## Interface
- `START_HOLD`, default 4: cycles `start_mining` is held high; must be ≥3 because the miner double-registers it.
- `ARM_TIMEOUT`, default 16: cycles allowed in WAIT_BUSY for `miner_busy` to rise.
- `DRAIN`, default 6: grace cycles after `miner_busy` falls during which `got_ticket` is still watched.
- `RX_GAP`, default 1000000: idle cycles that discard a partial frame; used only with `MINER_DISPATCH_RXGAP_EN`.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  byte strobe; byte accepted when `rx_valid && rx_ready`.
- `rx_ready`  out  1  low only while a full frame is buffered and a job is pending.
- `midstate`  out  256  job midstate to miner; stable between jobs.
- `data2`  out  96  job data tail to miner.
- `start_mining`  out  1  job start level pulse.
- `miner_busy`  in  1  miner running.
- `got_ticket`  in  1  miner sticky ticket flag.
- `golden_nonce`  in  32  miner result, valid while `got_ticket`.
- `tx_data`  out  8  result byte.
- `tx_valid`  out  1  result byte valid.
- `tx_ready`  in  1  transmitter accepts byte.
- `dispatch_busy`  out  1  high whenever the state is not IDLE.
- `err_arm`  out  1  one-cycle pulse on an ARM_TIMEOUT expiry.

## Operation
- Frame assembly: 352-bit shift register plus a 6-bit byte count. Each accepted byte enters at bits [351:344] and the register shifts right by 8. After 44 bytes, byte k sits at [8k+7:8k].
- Frame split: bits [255:0] go to midstate and [351:256] to data2. Byte 0 is therefore midstate[7:0], and byte 32 is data2[7:0].
- Frame completion: the 44th accept sets `job_pending` and clears the count. Reception continues into the shift register regardless of state. `rx_ready`=0 while `job_pending` is set and 44 new bytes are already buffered.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, RUN, DRAIN, SEND.
- IDLE: `job_pending` → LOAD.
- LOAD (1 cycle): copy the frame into `midstate`/`data2`, clear `job_pending` → START.
- START: `start_mining`=1 for START_HOLD cycles → WAIT_BUSY.
- WAIT_BUSY: `miner_busy`=1 → RUN. After ARM_TIMEOUT cycles without it → IDLE, with an `err_arm` pulse.
- RUN: `got_ticket`=1 → latch `golden_nonce` into the result register → SEND. `miner_busy`=0 → DRAIN.
- DRAIN: `got_ticket`=1 → latch → SEND. After DRAIN cycles without it → IDLE. No bytes are sent when the nonce range is exhausted.
- Ticket vs. busy ordering: the miner drops busy about one cycle before raising `got_ticket`; DRAIN covers this gap.
- SEND: transmit the result LSB first, bytes [7:0], [15:8], [23:16], [31:24], then → IDLE.
- Abort: `job_pending` in RUN or DRAIN → LOAD, abandoning the current job. In START, WAIT_BUSY or SEND, `job_pending` waits until the state ends.
- `got_ticket` is ignored outside RUN/DRAIN. The miner's stale ticket from the previous job clears before `miner_busy` rises.
- Widths: the byte counter saturates at 44. The hold, timeout and drain counters are sized by clog2 of their parameter and never wrap.

## Timing
- Reset values: `midstate`=0, `data2`=0, `start_mining`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1, `dispatch_busy`=0, `err_arm`=0, state IDLE, count 0, `job_pending`=0.
- Reset mid-operation drops `start_mining` and `tx_valid` immediately and discards any partial frame.
- All outputs are registered.
- 44th accept at edge N (from IDLE): LOAD during cycle N+1. `midstate`/`data2` update and `start_mining` rises at edge N+2 and stays high through edge N+2+START_HOLD.
- Ticket latency: `got_ticket` high at edge T → `tx_valid`=1 with `tx_data`=nonce[7:0] from edge T+1.
- Handshake: `tx_data` is held stable while `tx_valid && !tx_ready`. The next byte is presented the cycle after a transfer, so 4 bytes take at least 4 cycles.
- Simultaneous events: in RUN, `got_ticket` and `job_pending` in the same cycle → ticket wins, and the pending job starts after SEND.

## Configuration
- `MINER_DISPATCH_RXGAP_EN` defined: a 32-bit gap counter resets on every accept. If count≠0 and the gap reaches RX_GAP, the count returns to 0 and the partial frame is discarded; `job_pending` is unaffected.
- Not defined: no gap logic, and partial frames persist indefinitely.

## Test plan
- Bytes 0x00..0x2B after reset → `midstate`[7:0]=0x00, `midstate`[255:248]=0x1F, `data2`[7:0]=0x20, `data2`[95:88]=0x2B; `start_mining` high exactly 4 cycles.
- Miner model raises busy, then drops busy and raises `got_ticket` one cycle later with nonce 0x1234ABCD; `tx_ready` toggles → bytes CD, AB, 34, 12 in order.
- Miner model never raises busy → `err_arm` pulses once 16 cycles after `start_mining` falls; state returns to IDLE; no tx.
- Miner busy falls with no ticket → no tx, IDLE after 6 cycles. A ticket arriving 3 cycles after busy falls → 4 bytes sent.
- Second 44-byte frame completes during RUN → LOAD, new `midstate` applied, `start_mining` re-pulses; the old job produces no tx.
- With `MINER_DISPATCH_RXGAP_EN` and RX_GAP=100: send 10 bytes, idle 100 cycles, send 44 bytes → the job equals the last 44 bytes only.
